// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp sequencer.
// The optional retarget feature is enabled by defining PWM_RAMP_RETARGET_EN.
package pwm_pkg;

   localparam int         WIDTH_DEF   = 8;
   localparam int         DIV_W_DEF   = 8;
   localparam logic [7:0] ARR_RST_DEF = 8'hFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_e;

endpackage

// File: rtl/pwm_step_calc.sv
// Saturating single step of cur toward tgt; never overshoots tgt and never wraps.
// Shared with the multi-channel sequencers.
module pwm_step_calc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] tgt_i,
   input  logic [WIDTH-1:0] step_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] lim_w;

   // One extra bit so neither the up sum nor the down limit can wrap
   assign sum_w = {1'b0, cur_i} + {1'b0, step_i};
   assign lim_w = {1'b0, tgt_i} + {1'b0, step_i};

   always_comb begin
      next_o = tgt_i;
      if (cur_i <= tgt_i) begin
         if (sum_w < {1'b0, tgt_i}) begin
            next_o = sum_w[WIDTH-1:0];
         end
      end else begin
         if ({1'b0, cur_i} >= lim_w) begin
            next_o = cur_i - step_i;
         end
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty sequencer feeding pwm_gen arr/ccr; steps ccr toward a target every N periods.
// Define PWM_RAMP_RETARGET_EN to accept new commands while a ramp is running.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int               WIDTH   = WIDTH_DEF,
   parameter int               DIV_W   = DIV_W_DEF,
   parameter logic [WIDTH-1:0] ARR_RST = WIDTH'(ARR_RST_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             period_tick,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic [WIDTH-1:0] cmd_step,
   input  logic [WIDTH-1:0] cmd_arr,
   input  logic [DIV_W-1:0] cmd_periods,
   output logic [WIDTH-1:0] arr_out,
   output logic [WIDTH-1:0] ccr_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] arr_q, arr_d;
   logic [WIDTH-1:0] ccr_q, ccr_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] arr_sh_q, arr_sh_d;
   logic [DIV_W-1:0] per_q, per_d;
   logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             first_q, first_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   logic             accept_w;
   logic             counted_w;
   logic [WIDTH-1:0] clamp_w;
   logic [WIDTH-1:0] step_next_w;
   logic [DIV_W:0]   tick_inc_w;

   pwm_step_calc #(
      .WIDTH (WIDTH)
   ) u_step_calc (
      .cur_i  (ccr_q),
      .tgt_i  (tgt_q),
      .step_i (step_q),
      .next_o (step_next_w)
   );

   assign accept_w   = cmd_valid && ready_q;
   assign counted_w  = (state_q == ST_RAMP) && enable && period_tick;
   assign clamp_w    = (ccr_q > arr_sh_q) ? arr_sh_q : ccr_q;
   assign tick_inc_w = {1'b0, tick_cnt_q} + {{DIV_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         arr_q      <= ARR_RST;
         ccr_q      <= '0;
         tgt_q      <= '0;
         step_q     <= '0;
         arr_sh_q   <= ARR_RST;
         per_q      <= '0;
         tick_cnt_q <= '0;
         first_q    <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         arr_q      <= arr_d;
         ccr_q      <= ccr_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         arr_sh_q   <= arr_sh_d;
         per_q      <= per_d;
         tick_cnt_q <= tick_cnt_d;
         first_q    <= first_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   // A command always wins over a tick on the same edge (only reachable with retargeting)
   always_comb begin
      state_d    = state_q;
      arr_d      = arr_q;
      ccr_d      = ccr_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      arr_sh_d   = arr_sh_q;
      per_d      = per_q;
      tick_cnt_d = tick_cnt_q;
      first_d    = first_q;
      if (accept_w) begin
         tgt_d      = (cmd_target < cmd_arr) ? cmd_target : cmd_arr;
         step_d     = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
         per_d      = (cmd_periods == '0) ? DIV_W'(1) : cmd_periods;
         arr_sh_d   = cmd_arr;
         tick_cnt_d = '0;
         first_d    = 1'b1;
         state_d    = ST_RAMP;
      end else if (counted_w) begin
         if (first_q) begin
            // First tick only commits the shadowed arr and clamps ccr under it
            first_d = 1'b0;
            arr_d   = arr_sh_q;
            ccr_d   = clamp_w;
            if (clamp_w == tgt_q) begin
               state_d = ST_IDLE;
            end
         end else if (tick_inc_w == {1'b0, per_q}) begin
            tick_cnt_d = '0;
            ccr_d      = step_next_w;
            if (step_next_w == tgt_q) begin
               state_d = ST_IDLE;
            end
         end else begin
            tick_cnt_d = tick_inc_w[DIV_W-1:0];
         end
      end
   end

   always_comb begin
`ifdef PWM_RAMP_RETARGET_EN
      ready_d = 1'b1;
`else
      ready_d = (state_d == ST_IDLE);
`endif
      done_d    = (state_q == ST_RAMP) && (state_d == ST_IDLE);
      busy      = (state_q == ST_RAMP);
      cmd_ready = ready_q;
      done      = done_q;
      arr_out   = arr_q;
      ccr_out   = ccr_q;
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a path-list reference model predicts outputs per edge.
// Build with PWM_RAMP_RETARGET_EN to exercise mid-ramp retargeting.
module tb_pwm_ramp_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       period_tick;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_target;
   logic [7:0] cmd_step;
   logic [7:0] cmd_arr;
   logic [7:0] cmd_periods;
   logic [7:0] arr_out;
   logic [7:0] ccr_out;
   logic       busy;
   logic       done;

   pwm_ramp_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .period_tick (period_tick),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_target  (cmd_target),
      .cmd_step    (cmd_step),
      .cmd_arr     (cmd_arr),
      .cmd_periods (cmd_periods),
      .arr_out     (arr_out),
      .ccr_out     (ccr_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int arr;
      int ccr;
      bit ready;
      bit busy;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_cycle  = 0;

   // Reference model: a ramp is the list of ccr values still to visit, one every m_per ticks
   int m_arr, m_ccr, m_tgt, m_step, m_per, m_arrsh, m_countdown;
   bit m_active, m_first, m_ready, m_done, m_acc;
   int m_path[$];

   function automatic void build_path();
      int c;
      m_path.delete();
      c = m_ccr;
      while (c != m_tgt) begin
         if (c < m_tgt) c = (c + m_step > m_tgt) ? m_tgt : c + m_step;
         else           c = (c - m_step < m_tgt) ? m_tgt : c - m_step;
         m_path.push_back(c);
      end
   endfunction

   function automatic void model_edge(bit r, bit en, bit tk, bit v, int t, int s, int a, int p);
      m_done = 1'b0;
      m_acc  = 1'b0;
      if (!r) begin
         m_arr = 255; m_ccr = 0; m_ready = 1'b0; m_active = 1'b0; m_first = 1'b0;
         m_path.delete();
         return;
      end
      if (v && m_ready) begin
         m_acc    = 1'b1;
         m_tgt    = (t < a) ? t : a;
         m_step   = (s == 0) ? 1 : s;
         m_per    = (p == 0) ? 1 : p;
         m_arrsh  = a;
         m_active = 1'b1;
         m_first  = 1'b1;
      end else if (m_active && en && tk) begin
         if (m_first) begin
            m_first = 1'b0;
            m_arr   = m_arrsh;
            if (m_ccr > m_arrsh) m_ccr = m_arrsh;
            build_path();
            m_countdown = m_per;
            if (m_path.size() == 0) begin
               m_done = 1'b1; m_active = 1'b0;
            end
         end else begin
            m_countdown--;
            if (m_countdown == 0) begin
               m_ccr = m_path.pop_front();
               m_countdown = m_per;
               if (m_path.size() == 0) begin
                  m_done = 1'b1; m_active = 1'b0;
               end
            end
         end
      end
`ifdef PWM_RAMP_RETARGET_EN
      m_ready = 1'b1;
`else
      m_ready = !m_active;
`endif
   endfunction

   task automatic cycle(input bit r, input bit en, input bit tk, input bit v,
                        input int t, input int s, input int a, input int p);
      exp_t e;
      reset       = r;
      enable      = en;
      period_tick = tk;
      cmd_valid   = v;
      cmd_target  = 8'(t);
      cmd_step    = 8'(s);
      cmd_arr     = 8'(a);
      cmd_periods = 8'(p);
      @(posedge clk);
      #1;
      n_cycle++;
      model_edge(r, en, tk, v, t, s, a, p);
      e.arr = m_arr; e.ccr = m_ccr; e.ready = m_ready; e.busy = m_active; e.done = m_done;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input int tp, input bit en);
      for (int i = 0; i < n; i++) cycle(1'b1, en, (i % tp) == tp - 1, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic run_rand(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 3));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic send(input int t, input int s, input int a, input int p);
      int guard;
      guard = 0;
      do begin
         cycle(1'b1, 1'b1, (guard % 4) == 3, 1'b1, t, s, a, p);
         guard++;
      end while (!m_acc && guard < 20000);
      if (!m_acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL cmd_accept: not accepted after %0d cycles, required accept", guard);
      end else begin
         $display("cyc %0d cmd target=%0d step=%0d arr=%0d periods=%0d accepted after %0d cycles",
                  n_cycle, t, s, a, p, guard);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (int'(arr_out) != e.arr || int'(ccr_out) != e.ccr || cmd_ready !== e.ready ||
             busy !== e.busy || done !== e.done) begin
            n_errors++;
            $display("FAIL outputs @%0t: got arr=%0d ccr=%0d ready=%b busy=%b done=%b, required arr=%0d ccr=%0d ready=%b busy=%b done=%b",
                     $time, arr_out, ccr_out, cmd_ready, busy, done,
                     e.arr, e.ccr, e.ready, e.busy, e.done);
         end
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(3);
      run(3, 10, 1'b1);

      // Up-ramp 0 -> 40, steps of 16 every 2 periods
      send(40, 16, 100, 2);
      run(80, 10, 1'b1);

      // Down-ramp with arr clamp: target clamps to 30, done on first tick
      send(200, 5, 30, 1);
      run(20, 10, 1'b1);

      // Freeze mid-ramp for several ticks, then resume
      send(0, 4, 200, 3);
      run(45, 10, 1'b1);
      run(50, 10, 1'b0);
      run(150, 10, 1'b1);

      // Zero step/periods from 0
      do_reset(1);
      send(3, 0, 50, 0);
      run(60, 10, 1'b1);

      // Reset mid-ramp at ccr=32
      do_reset(1);
      send(200, 16, 255, 1);
      run(30, 10, 1'b1);
      do_reset(1);
      run(5, 10, 1'b1);

      // New command mid-ramp: retargets when enabled, otherwise waits for completion
      send(200, 16, 255, 1);
      run(30, 10, 1'b1);
      send(10, 3, 255, 2);
      run(120, 5, 1'b1);

      // Randomised commands, ticks, enable and occasional resets
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 14) == 0) do_reset(1);
         send($urandom_range(0, 255), $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 60),
              $urandom_range(0, 255), $urandom_range(0, 4));
         run_rand($urandom_range(20, 200));
      end

      run(3, 10, 1'b1);
      while (exp_q.size() > 0) @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
